vga_pixel_scanner: RTL and testbench
====================================

# vga_pixel_scanner

Raster timing source for the VGA object pipeline. Generates the `pixelX`/`pixelY` scan coordinates that every object drawer compares against its bracket. Accepts the merged 8-bit RGB332 colour returned by the object mux after the drawers' registered latency, and drives the display: `hSync`, `vSync` and 4-bit-per-channel colour, all aligned to that returned colour.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- PIPE_DELAY, 2, pixel ticks between coordinate output and valid `RGBin`; legal range 1..4
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixelEn  in  1  pixel tick; all state advances only on clk edges where pixelEn=1
- RGBin  in  8  merged RGB332 colour {R[2:0],G[2:0],B[1:0]} for the position issued PIPE_DELAY ticks earlier
- pixelX  out  11  current column, 0..H_TOTAL-1
- pixelY  out  11  current line, 0..V_TOTAL-1
- startOfFrame  out  1  one-clk pulse on the wrap to (0,0)
- hSync  out  1  horizontal sync, delay-aligned
- vSync  out  1  vertical sync, delay-aligned
- blankN  out  1  1 inside the visible area, delay-aligned
- vgaR, vgaG, vgaB  out  4 each  display colour

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Each pixelEn tick increments pixelX.
- When pixelX = H_TOTAL-1, the tick wraps pixelX to 0 and increments pixelY.
- When pixelY = V_TOTAL-1 at that line wrap, pixelY wraps to 0 and startOfFrame is high for that one clk.
- Raw per-position flags, from the current counters:
  - hs_raw = H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vs_raw = V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491)
  - de_raw = x < H_ACTIVE && y < V_ACTIVE
- {hs_raw, vs_raw, de_raw} enter a PIPE_DELAY-stage shift register that advances on pixelEn only.
- The output register loads on each pixelEn tick, from the last shift stage plus RGBin:
  - hSync/vSync = stage flag, inverted when SYNC_ACTIVE_LOW=1
  - blankN = de
  - If de = 1: vgaR = {R,R[2]}, vgaG = {G,G[2]}, vgaB = {B,B}
  - If de = 0: vgaR/G/B = 0, regardless of RGBin (including transparent 8'hFF)
- pixelEn = 0: counters, shift stages and outputs hold. startOfFrame is 0.

## Timing
- Reset (asynchronous, immediate, also mid-frame):
  - pixelX = 0, pixelY = 0, startOfFrame = 0, blankN = 0, colour = 0
  - hSync/vSync inactive (1 when SYNC_ACTIVE_LOW)
  - all shift stages cleared to inactive/blank
- After reset release, scanning resumes from (0,0). No startOfFrame is issued for that start; the first pulse comes after H_TOTAL*V_TOTAL ticks.
- Coordinates change on the clk edge of each pixelEn tick.
- Display outputs for position (x,y) appear PIPE_DELAY+1 ticks after (x,y) is presented on pixelX/pixelY.
- startOfFrame is registered and asserted in the same clk that pixelX/pixelY become (0,0).

## Test plan
- Reset: hold reset high with pixelEn=1. Required: all outputs at the listed reset values; hSync=vSync=1 (SYNC_ACTIVE_LOW=1).
- Horizontal wrap: drive pixelEn=1 continuously. Required: pixelX 799→0 with pixelY 0→1. hSync is low for exactly 96 ticks, first low output tick = 656+PIPE_DELAY+1 ticks after pixelX=0.
- Frame period: count ticks between two startOfFrame pulses. Required: exactly 420000. vSync is low for exactly 1600 ticks per frame.
- Colour path with PIPE_DELAY=2, RGBin held at 8'hE3. Required: vgaR=F, vgaG=0, vgaB=F inside the visible area; all zero while blankN=0. With RGBin=8'h49: vgaR=4, vgaG=4, vgaB=5.
- Tick gating: pixelEn toggling 1/0 every clk. Required: the frame takes 840000 clks; outputs are stable on clks with pixelEn=0.
- Mid-frame reset: assert reset at pixelX=300, pixelY=200 for 3 clks. Required: immediate return to reset values, restart at (0,0), no startOfFrame until 420000 ticks later.

Source files
------------

// File: rtl/vga_pixel_scanner.sv
// vga_pixel_scanner: raster timing source for the VGA object pipeline.
// Scans pixelX/pixelY, delays sync/blank flags to match the returned
// RGB332 colour and drives hSync/vSync/blankN and 4-bit colour.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   pixelEn      pixel tick; all state advances only when high
//   RGBin        merged RGB332 colour for the position issued
//                PIPE_DELAY ticks earlier
//   pixelX/Y     current scan column / line
//   startOfFrame one-clk pulse on the wrap to (0,0)
//   hSync/vSync  sync outputs, aligned to the colour
//   blankN       1 inside the visible area, aligned to the colour
//   vgaR/G/B     4-bit display colour
module vga_pixel_scanner #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int PIPE_DELAY      = 2,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixelEn,
    input  logic [7:0]  RGBin,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] Y_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] X_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] Y_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Level driven on the sync pins while the pulse is inactive.
    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } flags_t;

    localparam flags_t FLAGS_IDLE = '{hs: 1'b0, vs: 1'b0, de: 1'b0};

    logic   x_wrap;
    logic   y_wrap;
    flags_t raw;
    flags_t pipe [PIPE_DELAY];
    flags_t tail;
    logic [3:0] col_r;
    logic [3:0] col_g;
    logic [3:0] col_b;

    // ---------------------------------------------------------------
    // Scan counters
    // ---------------------------------------------------------------
    always_comb begin
        x_wrap = (pixelX == X_LAST);
        y_wrap = (pixelY == Y_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixelX       <= '0;
            pixelY       <= '0;
            startOfFrame <= 1'b0;
        end else begin
            startOfFrame <= 1'b0;
            if (pixelEn) begin
                if (x_wrap) begin
                    pixelX <= '0;
                    if (y_wrap) begin
                        pixelY       <= '0;
                        startOfFrame <= 1'b1;
                    end else begin
                        pixelY <= pixelY + 11'd1;
                    end
                end else begin
                    pixelX <= pixelX + 11'd1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Per-position flags, delayed to meet the returned colour
    // ---------------------------------------------------------------
    always_comb begin
        raw    = FLAGS_IDLE;
        raw.hs = (pixelX >= HS_BEG) && (pixelX < HS_END);
        raw.vs = (pixelY >= VS_BEG) && (pixelY < VS_END);
        raw.de = (pixelX < X_VIS) && (pixelY < Y_VIS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DELAY; i++) begin
                pipe[i] <= FLAGS_IDLE;
            end
        end else if (pixelEn) begin
            pipe[0] <= raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail = pipe[PIPE_DELAY-1];

    // ---------------------------------------------------------------
    // RGB332 -> 4:4:4 expansion, forced black outside the visible area
    // so a transparent key colour never reaches the display.
    // ---------------------------------------------------------------
    always_comb begin
        col_r = '0;
        col_g = '0;
        col_b = '0;
        if (tail.de) begin
            col_r = {RGBin[7:5], RGBin[7]};
            col_g = {RGBin[4:2], RGBin[4]};
            col_b = {RGBin[1:0], RGBin[1:0]};
        end
    end

    // ---------------------------------------------------------------
    // Output register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hSync  <= SYNC_IDLE;
            vSync  <= SYNC_IDLE;
            blankN <= 1'b0;
            vgaR   <= '0;
            vgaG   <= '0;
            vgaB   <= '0;
        end else if (pixelEn) begin
            hSync  <= tail.hs ^ SYNC_IDLE;
            vSync  <= tail.vs ^ SYNC_IDLE;
            blankN <= tail.de;
            vgaR   <= col_r;
            vgaG   <= col_g;
            vgaB   <= col_b;
        end
    end

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// tb_vga_pixel_scanner: directed bench for vga_pixel_scanner.
// Full-size instance for line timing/colour, small instance for frames.
module tb_vga_pixel_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       pixelEn;
    logic [7:0] RGBin;

    always #5 clk = ~clk;

    logic [10:0] d_pixelX, d_pixelY;
    logic        d_sof, d_hSync, d_vSync, d_blankN;
    logic [3:0]  d_vgaR, d_vgaG, d_vgaB;

    logic [10:0] s_pixelX, s_pixelY;
    logic        s_sof, s_hSync, s_vSync, s_blankN;
    logic [3:0]  s_vgaR, s_vgaG, s_vgaB;

    // Default 640x480 timing, PIPE_DELAY=2, active-low syncs.
    vga_pixel_scanner dut (
        .clk          (clk),
        .reset        (reset),
        .pixelEn      (pixelEn),
        .RGBin        (RGBin),
        .pixelX       (d_pixelX),
        .pixelY       (d_pixelY),
        .startOfFrame (d_sof),
        .hSync        (d_hSync),
        .vSync        (d_vSync),
        .blankN       (d_blankN),
        .vgaR         (d_vgaR),
        .vgaG         (d_vgaG),
        .vgaB         (d_vgaB)
    );

    // Small raster: H_TOTAL=32, V_TOTAL=12, frame=384 ticks,
    // hs x=23..27, vs y=8..9, PIPE_DELAY=3, active-high syncs.
    vga_pixel_scanner #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
        .PIPE_DELAY(3), .SYNC_ACTIVE_LOW(1'b0)
    ) sml (
        .clk          (clk),
        .reset        (reset),
        .pixelEn      (pixelEn),
        .RGBin        (RGBin),
        .pixelX       (s_pixelX),
        .pixelY       (s_pixelY),
        .startOfFrame (s_sof),
        .hSync        (s_hSync),
        .vSync        (s_vSync),
        .blankN       (s_blankN),
        .vgaR         (s_vgaR),
        .vgaG         (s_vgaG),
        .vgaB         (s_vgaB)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [73:0] snap();
        return {d_pixelX, d_pixelY, d_hSync, d_vSync, d_blankN,
                d_vgaR, d_vgaG, d_vgaB,
                s_pixelX, s_pixelY, s_hSync, s_vSync, s_blankN,
                s_vgaR, s_vgaG, s_vgaB};
    endfunction

    int d_first_hs, d_hs_low, d_sof_cnt;
    int s_sof_cnt, s_vs_hi, s_hs_hi;
    int s_sof_k [2];
    int sof_c, sof_n, unstable;
    logic [73:0] prev;

    initial begin
        reset   = 1'b1;
        pixelEn = 1'b1;
        RGBin   = 8'hE3;
        step(3);

        // Reset values
        chk("rst_x",     32'(d_pixelX), 0);
        chk("rst_y",     32'(d_pixelY), 0);
        chk("rst_sof",   32'(d_sof), 0);
        chk("rst_hs",    32'(d_hSync), 1);
        chk("rst_vs",    32'(d_vSync), 1);
        chk("rst_blank", 32'(d_blankN), 0);
        chk("rst_rgb",   32'({d_vgaR, d_vgaG, d_vgaB}), 0);
        chk("rst_s_hs",  32'(s_hSync), 0);
        chk("rst_s_vs",  32'(s_vSync), 0);
        chk("rst_s_xy",  32'({s_pixelX, s_pixelY}), 0);

        // Free-running scan: line timing, colour, small-frame period
        reset      = 1'b0;
        d_first_hs = -1;
        d_hs_low   = 0;
        d_sof_cnt  = 0;
        s_sof_cnt  = 0;
        s_vs_hi    = 0;
        s_hs_hi    = 0;
        s_sof_k[0] = -1;
        s_sof_k[1] = -1;
        for (int k = 1; k <= 1536; k++) begin
            step(1);
            if (k <= 800 && d_hSync === 1'b0) begin
                if (d_first_hs < 0) d_first_hs = k;
                d_hs_low++;
            end
            if (k <= 384 && s_vSync === 1'b1) s_vs_hi++;
            if (k <= 32 && s_hSync === 1'b1) s_hs_hi++;
            if (d_sof === 1'b1) d_sof_cnt++;
            if (s_sof === 1'b1) begin
                if (s_sof_cnt < 2) s_sof_k[s_sof_cnt] = k;
                if (s_sof_cnt == 0)
                    chk("sof_xy", 32'({s_pixelX, s_pixelY}), 0);
                s_sof_cnt++;
            end
            case (k)
                2:   chk("blank_k2", 32'(d_blankN), 0);
                3:   chk("blank_k3", 32'(d_blankN), 1);
                100: chk("rgb_e3", 32'({d_vgaR, d_vgaG, d_vgaB}), 32'h0F0F);
                259: chk("s_vs_k259", 32'(s_vSync), 0);
                260: chk("s_vs_k260", 32'(s_vSync), 1);
                642: chk("blank_k642", 32'(d_blankN), 1);
                643: chk("blank_k643", 32'(d_blankN), 0);
                700: chk("rgb_blank", 32'({d_vgaR, d_vgaG, d_vgaB}), 0);
                799: chk("wrap_799", 32'({d_pixelX, d_pixelY}),
                         32'({11'd799, 11'd0}));
                800: begin
                    chk("wrap_800", 32'({d_pixelX, d_pixelY}),
                        32'({11'd0, 11'd1}));
                    RGBin = 8'h49;
                end
                820: begin
                    chk("rgb_49", 32'({d_vgaR, d_vgaG, d_vgaB}), 32'h0445);
                    RGBin = 8'hFF;
                end
                1503: chk("rgb_ff_blank",
                          32'({d_blankN, d_vgaR, d_vgaG, d_vgaB}), 0);
                default: ;
            endcase
        end
        chk("hs_first",   32'(d_first_hs), 659);
        chk("hs_width",   32'(d_hs_low), 96);
        chk("d_no_sof",   32'(d_sof_cnt), 0);
        chk("s_hs_width", 32'(s_hs_hi), 5);
        chk("s_vs_width", 32'(s_vs_hi), 64);
        chk("sof_first",  32'(s_sof_k[0]), 384);
        chk("sof_period", 32'(s_sof_k[1] - s_sof_k[0]), 384);
        chk("sof_count",  32'(s_sof_cnt), 4);

        // Tick gating: pixelEn 0,1,0,1... from the first clk
        reset = 1'b1;
        step(2);
        reset    = 1'b0;
        sof_c    = -1;
        sof_n    = 0;
        unstable = 0;
        for (int c = 1; c <= 800; c++) begin
            pixelEn = (c % 2 == 0);
            prev    = snap();
            step(1);
            if (!pixelEn && snap() !== prev) unstable++;
            if (s_sof === 1'b1) begin
                if (sof_c < 0) sof_c = c;
                sof_n++;
            end
        end
        chk("gate_sof_clk", 32'(sof_c), 768);
        chk("gate_sof_n",   32'(sof_n), 1);
        chk("gate_stable",  32'(unstable), 0);

        // Mid-frame reset on the small raster at (10,3)
        pixelEn = 1'b1;
        reset   = 1'b1;
        step(2);
        reset = 1'b0;
        step(106);
        chk("mid_xy",    32'({s_pixelX, s_pixelY}), 32'({11'd10, 11'd3}));
        chk("mid_blank", 32'(s_blankN), 1);
        chk("mid_rgb",   32'({s_vgaR, s_vgaG, s_vgaB}), 32'h0FFF);
        #2 reset = 1'b1;
        #1;
        chk("async_s_xy",    32'({s_pixelX, s_pixelY}), 0);
        chk("async_s_blank", 32'({s_blankN, s_vgaR, s_vgaG, s_vgaB}), 0);
        chk("async_s_hs",    32'(s_hSync), 0);
        chk("async_d_x",     32'(d_pixelX), 0);
        chk("async_d_hs",    32'(d_hSync), 1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sof_c = -1;
        sof_n = 0;
        for (int t = 1; t <= 400; t++) begin
            step(1);
            if (t == 1) chk("restart_x", 32'(s_pixelX), 1);
            if (s_sof === 1'b1) begin
                if (sof_c < 0) sof_c = t;
                sof_n++;
            end
        end
        chk("mid_sof_tick", 32'(sof_c), 384);
        chk("mid_sof_n",    32'(sof_n), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
